// File: rtl/led_on_pkg.sv
// rtl/led_on_pkg.sv - shared defaults and types for the led_on LED driver
package led_on_pkg;

  localparam int LED_SYNC_STAGES_DEF = 2;
  localparam int LED_DEBOUNCE_DEF    = 4;
  localparam int LED_PWM_BITS_DEF    = 8;

  typedef logic [15:0] db_cnt_t;

endpackage

// File: rtl/led_on_debounce.sv
// rtl/led_on_debounce.sv - on_in synchroniser plus debounce, produces on_state
module led_on_debounce
  import led_on_pkg::*;
#(
  parameter int SYNC_STAGES     = LED_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = LED_DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic on_in,
  output logic on_state
);

  localparam db_cnt_t DB_LAST = db_cnt_t'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_req;
  db_cnt_t                db_cnt;

  assign sync_req = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous request through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], on_in};
    end
  end

  // Accept a new level only after it has differed from on_state for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= '0;
      on_state <= 1'b0;
    end else if (sync_req == on_state) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      on_state <= sync_req;
      db_cnt   <= '0;
    end else begin
      db_cnt <= db_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/led_on.sv
// rtl/led_on.sv - single LED driver; PWM dimming built when LED_ON_PWM_EN is defined
module led_on
  import led_on_pkg::*;
#(
  parameter int SYNC_STAGES     = LED_SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = LED_DEBOUNCE_DEF,
  parameter int PWM_BITS        = LED_PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                on_in,
  input  logic [PWM_BITS-1:0] duty,
  output logic                out,
  output logic                on_state
);

  led_on_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .on_in    (on_in),
    .on_state (on_state)
  );

`ifdef LED_ON_PWM_EN

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;

  // Free-run the period counter only while lit; duty is sampled at each period start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      if (!on_state) begin
        pwm_cnt <= '0;
      end else begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
      if (pwm_cnt == '0) begin
        duty_q <= duty;
      end
    end
  end

  // Registered dimmed drive; on_state low forces the LED off on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else begin
      out <= on_state && (pwm_cnt < duty_q);
    end
  end

`else

  logic unused_duty;
  assign unused_duty = ^duty;

  // Registered full-brightness drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 1'b0;
    end else begin
      out <= on_state;
    end
  end

`endif

endmodule

// File: tb/tb_led_on.sv
// tb/tb_led_on.sv - directed table-driven bench for led_on (PWM checks when LED_ON_PWM_EN is defined)
module tb_led_on;

  localparam int PWM_BITS = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                on_in = 1'b1;
  logic [PWM_BITS-1:0] duty = 4'hF;
  logic                out;
  logic                on_state;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic on_in;
    logic exp_on;
    logic exp_out;
  } vec_t;

  vec_t vecs[$];

  led_on #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .PWM_BITS        (PWM_BITS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .on_in    (on_in),
    .duty     (duty),
    .out      (out),
    .on_state (on_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic add(input int n, input logic i, input logic eo, input logic ex);
    vec_t v;
    v.on_in   = i;
    v.exp_on  = eo;
    v.exp_out = ex;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  initial begin
    // Edge-by-edge schedule after reset release; entry n is edge n+1.
    add(5, 1'b1, 1'b0, 1'b0);   // turn-on latency
    add(1, 1'b1, 1'b1, 1'b0);   // on_state rises at edge 6
    add(2, 1'b1, 1'b1, 1'b1);   // out rises at edge 7
    add(2, 1'b0, 1'b1, 1'b1);   // 2-clock glitch low
    add(4, 1'b1, 1'b1, 1'b1);   // rejected
    add(5, 1'b0, 1'b1, 1'b1);   // turn-off starts
    add(1, 1'b0, 1'b0, 1'b1);   // on_state falls one edge before out
    add(2, 1'b0, 1'b0, 1'b0);
    add(4, 1'b1, 1'b0, 1'b0);   // exactly 4-clock high pulse
    add(1, 1'b0, 1'b0, 1'b0);
    add(1, 1'b0, 1'b1, 1'b0);   // accepted
    add(3, 1'b0, 1'b1, 1'b1);
    add(1, 1'b0, 1'b0, 1'b1);
    add(2, 1'b0, 1'b0, 1'b0);
    add(3, 1'b1, 1'b0, 1'b0);   // 3-clock pulse rejected
    add(7, 1'b0, 1'b0, 1'b0);

    // Reset held with on_in high: LED stays off.
    rst_n = 1'b0;
    on_in = 1'b1;
    duty  = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_out", i, out, 1'b0);
      check("reset_on_state", i, on_state, 1'b0);
    end
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      on_in = vecs[i].on_in;
      @(posedge clk);
      #1;
      check("vec_on_state", i + 1, on_state, vecs[i].exp_on);
      check("vec_out", i + 1, out, vecs[i].exp_out);
      @(negedge clk);
    end

    // Asynchronous reset while lit, then full restart latency.
    begin
      int waited;
      on_in  = 1'b1;
      waited = 0;
      while (out !== 1'b1 && waited < 20) begin
        @(posedge clk);
        #1;
        waited++;
      end
      check("relight_timeout", waited, out, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out", 0, out, 1'b0);
      check("async_rst_on_state", 0, on_state, 1'b0);
      rst_n = 1'b1;
      for (int e = 1; e <= 7; e++) begin
        @(posedge clk);
        #1;
        check("restart_out", e, out, (e == 7));
      end
    end

`ifdef LED_ON_PWM_EN
    // Duty 4 of 16, changed to 12 mid-period at pwm_cnt=6; takes effect next period.
    @(negedge clk);
    rst_n = 1'b0;
    duty  = 4'd4;
    on_in = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 54; e++) begin
      int   k;
      int   d;
      logic exp;
      @(posedge clk);
      #1;
      if (e < 7) begin
        exp = 1'b0;
      end else begin
        k   = e - 7;
        d   = (k / 16 == 0) ? 4 : 12;
        exp = ((k % 16) < d);
      end
      check("pwm_out", e, out, exp);
      if (e == 12) duty = 4'd12;
    end

    // Duty 0 keeps the LED dark while on_state is high.
    duty = 4'd0;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (e >= 20) check("pwm_zero_out", e, out, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_on.md
Name: led_on

Overview:
- Single-LED drive block for the KX1 PSU front panel.
- Takes an asynchronous on/off request `on_in`, synchronises and debounces it, and drives the LED output `out`.
- With PWM compiled in, `out` is dimmed to a programmable duty cycle.
- Sits between board-level control logic (or a pin) and the LED pad driver.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on `on_in` (legal values 2..4).
- DEBOUNCE_CYCLES, 4, consecutive clocks the synchronised request must hold a new level before it is accepted (1..65535).
- PWM_BITS, 8, width of the PWM counter and the `duty` port (4..16).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- on_in  input  1  LED request, asynchronous to clk; 1 = LED on.
- duty  input  PWM_BITS  brightness; on-time in clocks per 2^PWM_BITS period. Ignored unless LED_ON_PWM_EN is defined.
- out  output  1  LED drive, registered, active high.
- on_state  output  1  debounced request level, registered.

Interface decision: one clock; reset is asynchronous and active-low (ports clk and rst_n).

Behaviour:
- Reset (rst_n=0, asynchronous assert, synchronous deassert at the board level):
  - all synchroniser flops, debounce counter, on_state, PWM counter and out go to 0.
  - The LED is off during reset and immediately after it.
- Synchroniser:
  - `on_in` passes through SYNC_STAGES flops; the last stage is `sync_req`.
- Debounce:
  - 16-bit counter `db_cnt`.
  - If `sync_req` == `on_state`: `db_cnt` clears to 0.
  - Otherwise `db_cnt` increments.
  - When `db_cnt` reaches DEBOUNCE_CYCLES-1 while still mismatched, `on_state` takes `sync_req` on that edge and `db_cnt` clears.
  - Any return to a matching level before then aborts the change. Glitches shorter than DEBOUNCE_CYCLES clocks at `sync_req` are rejected.
- Output without PWM:
  - `out` is a register loaded from `on_state`.
  - Latency from the first rising edge that samples a new `on_in` level to `out` changing is SYNC_STAGES+DEBOUNCE_CYCLES+1 edges (7 with defaults). The same latency applies on both edges of the request.
- Output with PWM:
  - PWM counter `pwm_cnt`, PWM_BITS wide.
  - While `on_state`=0, `pwm_cnt` is held at 0 and `out`=0.
  - While `on_state`=1, `pwm_cnt` increments every clock and wraps from all-ones to 0.
  - `duty` is latched into `duty_q` whenever `pwm_cnt`==0, so changes take effect only at a period boundary, glitch-free.
  - `out` is registered: `on_state` && (`pwm_cnt` < `duty_q`).
  - duty=0 → `out` never high.
  - duty=all-ones → `out` high 2^PWM_BITS−1 of every 2^PWM_BITS clocks.
  - On the rising edge of `on_state`, the first period starts with `pwm_cnt`=0.
  - On the falling edge of `on_state`, `out` drops on the next edge regardless of PWM phase.
- Reset mid-operation: everything returns to the reset state at once; there is no memory of the prior request.
- Simultaneous events: a debounced change and a PWM wrap on the same edge follow the rules above independently; `on_state` going low always wins.

Optional Feature:
- Macro: LED_ON_PWM_EN.
- Defined: PWM dimming as described; the `duty` port is functional.
- Undefined:
  - no PWM counter or `duty_q` is built;
  - `out` = registered `on_state` (full brightness);
  - the `duty` port is still present but unused, so the port list is identical in both builds.

Decomposition:
- Package `led_on_pkg`:
  - default constants LED_SYNC_STAGES_DEF=2, LED_DEBOUNCE_DEF=4, LED_PWM_BITS_DEF=8;
  - typedef for the 16-bit debounce counter.
- Sub-module `led_on_debounce`: synchroniser plus debounce counter, producing `on_state`.
- The top level holds the optional PWM and the output register.

Test Plan:
1. Reset: rst_n=0 with on_in=1 → out=0 and on_state=0 throughout reset; after release with on_in=1 held, out=1 at the 7th rising edge (defaults, PWM off).
2. Glitch rejection: on_in held 1 and out=1, then on_in=0 for 2 clocks, then back to 1 → on_state and out stay 1.
3. Turn-off: on_in 1→0 held → out=0 exactly 7 edges after the first edge sampling 0; on_state falls one edge earlier.
4. PWM (LED_ON_PWM_EN, PWM_BITS=4, duty=4, on_in=1 held) → out high 4 of every 16 clocks, steady pattern once started.
5. Duty change mid-period (PWM build): duty 4→12 at pwm_cnt=6 → current period keeps 4 high clocks; the next period has 12.
6. Asynchronous reset mid-PWM: pulse rst_n low for 1 ns while out=1 → out=0 immediately without waiting for a clock; restart takes the full 7-edge latency (defaults).
